// File: rtl/kdtree_stream_loader_pkg.sv
// Shared constants and state encoding for the k-d tree stream loader.
package kdtree_stream_loader_pkg;

  localparam int DATA_WIDTH = 11;
  localparam int PATCH_SIZE = 5;
  localparam int LEAF_SIZE  = 8;
  localparam int NUM_LEAVES = 64;
  localparam int NUM_QUERYS = 494;
  localparam int IDX_WIDTH  = 9;
  localparam int LEAF_ADDRW = 6;

  // Derived sizes
  localparam int NUM_NODES       = NUM_LEAVES - 1;
  localparam int WORDS_PER_PATCH = PATCH_SIZE + 1;  // data words plus index word
  localparam int SLOT_W          = $clog2(LEAF_SIZE);
  localparam int QADDR_W         = $clog2(NUM_QUERYS);
  localparam int PATCH_W         = PATCH_SIZE * DATA_WIDTH;
  localparam int PCNT_W          = $clog2(WORDS_PER_PATCH);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_NODES,
    ST_LEAVES,
    ST_QUERIES,
    ST_DONE
  } state_t;

endpackage

// File: rtl/kdtree_stream_loader_if.sv
// Input FIFO read port plus the node, leaf and query write ports.
interface kdtree_stream_loader_if;
  import kdtree_stream_loader_pkg::*;

  logic                  fifo_rempty_n;
  logic [DATA_WIDTH-1:0] fifo_rdata;
  logic                  fifo_deq;

  logic                  node_wen;
  logic [LEAF_ADDRW-1:0] node_waddr;
  logic [2:0]            node_wdim;
  logic [DATA_WIDTH-1:0] node_wmedian;

  logic                  leaf_wen;
  logic [LEAF_ADDRW-1:0] leaf_waddr;
  logic [SLOT_W-1:0]     leaf_wslot;
  logic [PATCH_W-1:0]    leaf_wpatch;
  logic [IDX_WIDTH-1:0]  leaf_wpidx;

  logic                  query_wen;
  logic [QADDR_W-1:0]    query_waddr;
  logic [PATCH_W-1:0]    query_wpatch;

  // Loader side: pops the FIFO and drives the write ports
  modport master (
    input  fifo_rempty_n, fifo_rdata,
    output fifo_deq,
    output node_wen, node_waddr, node_wdim, node_wmedian,
    output leaf_wen, leaf_waddr, leaf_wslot, leaf_wpatch, leaf_wpidx,
    output query_wen, query_waddr, query_wpatch
  );

  // Environment side: FIFO and the memories being filled
  modport slave (
    output fifo_rempty_n, fifo_rdata,
    input  fifo_deq,
    input  node_wen, node_waddr, node_wdim, node_wmedian,
    input  leaf_wen, leaf_waddr, leaf_wslot, leaf_wpatch, leaf_wpidx,
    input  query_wen, query_waddr, query_wpatch
  );

endinterface

// File: rtl/kdtree_stream_loader_patch_packer.sv
// Word counter and shift/pack register shared by leaf and query patches.
// Data words shift in from the top so word 0 ends up at the LSBs.
module patch_packer
  import kdtree_stream_loader_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr_i,       // drop any partial patch
  input  logic                  word_vld_i,  // a word is accepted this cycle
  input  logic                  idx_mode_i,  // patch carries a trailing index word
  input  logic [DATA_WIDTH-1:0] word_i,
  output logic [PATCH_W-1:0]    patch_q_o,   // words packed so far
  output logic [PATCH_W-1:0]    patch_d_o,   // packed value including word_i
  output logic                  last_o       // word_i completes the patch
);

  logic [PCNT_W-1:0]  cnt_q;
  logic [PATCH_W-1:0] patch_q;
  logic [PCNT_W-1:0]  last_cnt;
  logic               data_word;

  assign last_cnt  = idx_mode_i ? PCNT_W'(PATCH_SIZE) : PCNT_W'(PATCH_SIZE - 1);
  assign data_word = (cnt_q < PCNT_W'(PATCH_SIZE));
  assign patch_d_o = {word_i, patch_q[PATCH_W-1:DATA_WIDTH]};
  assign patch_q_o = patch_q;
  assign last_o    = word_vld_i && (cnt_q == last_cnt);

  // Count words within a patch and shift data words into the pack register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      patch_q <= '0;
    end else if (clr_i) begin
      cnt_q   <= '0;
      patch_q <= '0;
    end else if (word_vld_i) begin
      cnt_q <= last_o ? '0 : cnt_q + 1'b1;
      if (data_word) patch_q <= patch_d_o;
    end
  end

endmodule

// File: rtl/kdtree_stream_loader.sv
// Streams internal nodes, leaf patches and query patches out of a FIFO
// into their respective memories, one word per cycle.
module kdtree_stream_loader
  import kdtree_stream_loader_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          load_kdtree,
  kdtree_stream_loader_if.master        bus,
  output logic                          busy,
  output logic                          done
);

  state_t                state_q;
  logic                  half_q;      // dimension word of the pair already taken
  logic [2:0]            dim_q;
  logic [LEAF_ADDRW-1:0] node_cnt_q;
  logic [LEAF_ADDRW-1:0] leaf_q;
  logic [SLOT_W-1:0]     slot_q;
  logic [QADDR_W-1:0]    query_q;

  logic                  node_wen_q, leaf_wen_q, query_wen_q, done_q;
  logic [LEAF_ADDRW-1:0] node_waddr_q, leaf_waddr_q;
  logic [2:0]            node_wdim_q;
  logic [DATA_WIDTH-1:0] node_wmedian_q;
  logic [SLOT_W-1:0]     leaf_wslot_q;
  logic [PATCH_W-1:0]    leaf_wpatch_q, query_wpatch_q;
  logic [IDX_WIDTH-1:0]  leaf_wpidx_q;
  logic [QADDR_W-1:0]    query_waddr_q;

  logic                  active, accept, pack_vld, pack_last;
  logic [PATCH_W-1:0]    patch_q, patch_d;

  assign active       = (state_q == ST_NODES) || (state_q == ST_LEAVES) ||
                        (state_q == ST_QUERIES);
  assign bus.fifo_deq = active && bus.fifo_rempty_n;
  assign accept       = bus.fifo_deq;
  assign pack_vld     = accept && ((state_q == ST_LEAVES) || (state_q == ST_QUERIES));

  patch_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (state_q == ST_IDLE),
    .word_vld_i (pack_vld),
    .idx_mode_i (state_q == ST_LEAVES),
    .word_i     (bus.fifo_rdata),
    .patch_q_o  (patch_q),
    .patch_d_o  (patch_d),
    .last_o     (pack_last)
  );

  // Sequencer: walks node pairs, leaf patches, query patches, then pulses done
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      half_q         <= 1'b0;
      dim_q          <= '0;
      node_cnt_q     <= '0;
      leaf_q         <= '0;
      slot_q         <= '0;
      query_q        <= '0;
      node_wen_q     <= 1'b0;
      node_waddr_q   <= '0;
      node_wdim_q    <= '0;
      node_wmedian_q <= '0;
      leaf_wen_q     <= 1'b0;
      leaf_waddr_q   <= '0;
      leaf_wslot_q   <= '0;
      leaf_wpatch_q  <= '0;
      leaf_wpidx_q   <= '0;
      query_wen_q    <= 1'b0;
      query_waddr_q  <= '0;
      query_wpatch_q <= '0;
      done_q         <= 1'b0;
    end else begin
      node_wen_q  <= 1'b0;
      leaf_wen_q  <= 1'b0;
      query_wen_q <= 1'b0;
      done_q      <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (load_kdtree) begin
            state_q    <= ST_NODES;
            half_q     <= 1'b0;
            node_cnt_q <= '0;
            leaf_q     <= '0;
            slot_q     <= '0;
            query_q    <= '0;
          end
        end
        ST_NODES: begin
          if (accept) begin
            if (!half_q) begin
              dim_q  <= bus.fifo_rdata[2:0];
              half_q <= 1'b1;
            end else begin
              half_q         <= 1'b0;
              node_wen_q     <= 1'b1;
              node_waddr_q   <= node_cnt_q;
              node_wdim_q    <= dim_q;
              node_wmedian_q <= bus.fifo_rdata;
              node_cnt_q     <= node_cnt_q + 1'b1;
              if (node_cnt_q == LEAF_ADDRW'(NUM_NODES - 1)) state_q <= ST_LEAVES;
            end
          end
        end
        ST_LEAVES: begin
          if (pack_last) begin
            leaf_wen_q    <= 1'b1;
            leaf_waddr_q  <= leaf_q;
            leaf_wslot_q  <= slot_q;
            leaf_wpatch_q <= patch_q;
            leaf_wpidx_q  <= bus.fifo_rdata[IDX_WIDTH-1:0];
            if (slot_q == SLOT_W'(LEAF_SIZE - 1)) begin
              slot_q <= '0;
              leaf_q <= leaf_q + 1'b1;
              if (leaf_q == LEAF_ADDRW'(NUM_LEAVES - 1)) state_q <= ST_QUERIES;
            end else begin
              slot_q <= slot_q + 1'b1;
            end
          end
        end
        ST_QUERIES: begin
          if (pack_last) begin
            query_wen_q    <= 1'b1;
            query_waddr_q  <= query_q;
            query_wpatch_q <= patch_d;
            query_q        <= query_q + 1'b1;
            if (query_q == QADDR_W'(NUM_QUERYS - 1)) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end
          end
        end
        ST_DONE:  state_q <= ST_IDLE;
        default:  state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy             = (state_q != ST_IDLE);
  assign done             = done_q;
  assign bus.node_wen     = node_wen_q;
  assign bus.node_waddr   = node_waddr_q;
  assign bus.node_wdim    = node_wdim_q;
  assign bus.node_wmedian = node_wmedian_q;
  assign bus.leaf_wen     = leaf_wen_q;
  assign bus.leaf_waddr   = leaf_waddr_q;
  assign bus.leaf_wslot   = leaf_wslot_q;
  assign bus.leaf_wpatch  = leaf_wpatch_q;
  assign bus.leaf_wpidx   = leaf_wpidx_q;
  assign bus.query_wen    = query_wen_q;
  assign bus.query_waddr  = query_waddr_q;
  assign bus.query_wpatch = query_wpatch_q;

endmodule

// File: tb/tb_kdtree_stream_loader.sv
// Self-checking bench for kdtree_stream_loader: a word-stream FIFO feeder,
// an index-based reference model and a per-cycle compare process.
module tb_kdtree_stream_loader;
  import kdtree_stream_loader_pkg::*;

  localparam int LBASE = 2 * NUM_NODES;
  localparam int QBASE = LBASE + NUM_LEAVES * LEAF_SIZE * WORDS_PER_PATCH;
  localparam int TOTAL = QBASE + NUM_QUERYS * PATCH_SIZE;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic load_kdtree = 1'b0;
  logic busy, done;

  kdtree_stream_loader_if bus_if();

  kdtree_stream_loader dut (
    .clk         (clk),
    .rst         (rst),
    .load_kdtree (load_kdtree),
    .bus         (bus_if),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Word stream: a deterministic filler with the directed words overlaid
  logic [DATA_WIDTH-1:0] stream [TOTAL];
  int  ptr       = 0;
  int  stall     = 0;
  bit  gap_en    = 1'b0;
  bit  gap_taken = 1'b0;

  function automatic logic [PATCH_W-1:0] pack(input int base, input int nw);
    logic [PATCH_W-1:0] p = '0;
    for (int k = 0; k < nw; k++)
      p = p | (PATCH_W'(stream[base + k]) << (DATA_WIDTH * k));
    return p;
  endfunction

  // FIFO feeder: first-word-fall-through head, optional 10-cycle gap in query 0
  initial begin : feeder
    bit acc;
    for (int i = 0; i < TOTAL; i++) stream[i] = DATA_WIDTH'((i * 37 + 11) % 2048);
    stream[0] = 11'd3;   stream[1] = 11'd512;
    stream[LBASE + 0] = 11'd1; stream[LBASE + 1] = 11'd2; stream[LBASE + 2] = 11'd3;
    stream[LBASE + 3] = 11'd4; stream[LBASE + 4] = 11'd5; stream[LBASE + 5] = 11'd77;
    stream[QBASE + 0] = 11'd100; stream[QBASE + 1] = 11'd200; stream[QBASE + 2] = 11'd300;
    stream[QBASE + 3] = 11'd400; stream[QBASE + 4] = 11'd500;
    bus_if.fifo_rempty_n = 1'b1;
    bus_if.fifo_rdata    = stream[0];
    forever begin
      @(negedge clk);
      acc = bus_if.fifo_deq && bus_if.fifo_rempty_n;
      @(posedge clk);
      #1;
      if (rst) begin
        ptr = 0; stall = 0; gap_taken = 1'b0;
      end else begin
        if (acc) ptr++;
        if (gap_en && !gap_taken && ptr == QBASE + 3) begin
          stall = 10; gap_taken = 1'b1;
        end else if (stall > 0) begin
          stall--;
        end
      end
      bus_if.fifo_rempty_n = (ptr < TOTAL) && (stall == 0);
      bus_if.fifo_rdata    = (ptr < TOTAL) ? stream[ptr] : '0;
    end
  end

  // Reference model + compare: the word accepted last cycle decides which strobe fires now
  int pend_idx = -1;
  bit model_run = 1'b0, go_pending = 1'b0, done_exp = 1'b0;
  int n_node = 0, n_leaf = 0, n_query = 0, n_done = 0;

  always @(negedge clk) begin
    bit exp_n, exp_l, exp_q;
    int n, p, q, j;
    if (rst) begin
      pend_idx = -1; model_run = 1'b0; go_pending = 1'b0; done_exp = 1'b0;
      n_node = 0; n_leaf = 0; n_query = 0; n_done = 0;
    end else begin
      done_exp = (pend_idx == TOTAL - 1);
      if (go_pending) begin model_run = 1'b1; go_pending = 1'b0; end
      if (done_exp) model_run = 1'b0;
      chk("fifo_deq", 64'(bus_if.fifo_deq), 64'(model_run && bus_if.fifo_rempty_n));
      chk("busy", 64'(busy), 64'(model_run || done_exp));
      chk("done", 64'(done), 64'(done_exp));

      exp_n = (pend_idx >= 0) && (pend_idx < LBASE) && (pend_idx % 2 == 1);
      exp_l = (pend_idx >= LBASE) && (pend_idx < QBASE) &&
              ((pend_idx - LBASE) % WORDS_PER_PATCH == WORDS_PER_PATCH - 1);
      exp_q = (pend_idx >= QBASE) && ((pend_idx - QBASE) % PATCH_SIZE == PATCH_SIZE - 1);
      chk("node_wen", 64'(bus_if.node_wen), 64'(exp_n));
      chk("leaf_wen", 64'(bus_if.leaf_wen), 64'(exp_l));
      chk("query_wen", 64'(bus_if.query_wen), 64'(exp_q));

      if (exp_n) begin
        n = pend_idx / 2;
        chk("node_waddr", 64'(bus_if.node_waddr), 64'(n));
        chk("node_wdim", 64'(bus_if.node_wdim), 64'(stream[2 * n][2:0]));
        chk("node_wmedian", 64'(bus_if.node_wmedian), 64'(stream[2 * n + 1]));
        if (n == 0) begin
          chk("node0_dim_lit", 64'(bus_if.node_wdim), 64'd3);
          chk("node0_median_lit", 64'(bus_if.node_wmedian), 64'd512);
        end
      end
      if (exp_l) begin
        p = (pend_idx - LBASE) / WORDS_PER_PATCH;
        j = LBASE + p * WORDS_PER_PATCH;
        chk("leaf_waddr", 64'(bus_if.leaf_waddr), 64'(p / LEAF_SIZE));
        chk("leaf_wslot", 64'(bus_if.leaf_wslot), 64'(p % LEAF_SIZE));
        chk("leaf_wpatch", 64'(bus_if.leaf_wpatch), 64'(pack(j, PATCH_SIZE)));
        chk("leaf_wpidx", 64'(bus_if.leaf_wpidx), 64'(stream[j + PATCH_SIZE][IDX_WIDTH-1:0]));
        if (p == 0) begin
          chk("leaf0_wpatch_lit", 64'(bus_if.leaf_wpatch),
              64'({11'd5, 11'd4, 11'd3, 11'd2, 11'd1}));
          chk("leaf0_wpidx_lit", 64'(bus_if.leaf_wpidx), 64'd77);
        end
      end
      if (exp_q) begin
        q = (pend_idx - QBASE) / PATCH_SIZE;
        chk("query_waddr", 64'(bus_if.query_waddr), 64'(q));
        chk("query_wpatch", 64'(bus_if.query_wpatch), 64'(pack(QBASE + q * PATCH_SIZE, PATCH_SIZE)));
        if (q == 0)
          chk("query0_wpatch_lit", 64'(bus_if.query_wpatch),
              64'({11'd500, 11'd400, 11'd300, 11'd200, 11'd100}));
      end

      if (bus_if.node_wen)  n_node++;
      if (bus_if.leaf_wen)  n_leaf++;
      if (bus_if.query_wen) n_query++;
      if (done)             n_done++;

      pend_idx = (bus_if.fifo_deq && bus_if.fifo_rempty_n) ? ptr : -1;
      if (load_kdtree && !model_run && !done_exp) go_pending = 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_load();
    load_kdtree = 1'b1;
    tick();
    load_kdtree = 1'b0;
  endtask

  initial begin : main
    int c;
    repeat (3) tick();
    // Reset state with a word waiting in the FIFO
    chk("rst_fifo_deq", 64'(bus_if.fifo_deq), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_node_wen", 64'(bus_if.node_wen), 64'd0);
    chk("rst_leaf_wen", 64'(bus_if.leaf_wen), 64'd0);
    chk("rst_query_wen", 64'(bus_if.query_wen), 64'd0);
    chk("rst_leaf_wpatch", 64'(bus_if.leaf_wpatch), 64'd0);
    rst = 1'b0;
    repeat (2) tick();

    // Partial load, reset in the middle of LEAVES
    pulse_load();
    for (c = 0; c < 4000 && n_leaf < 20; c++) tick();
    chk("wait_leaves", 64'(n_leaf >= 20), 64'd1);
    rst = 1'b1;
    #1;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_fifo_deq", 64'(bus_if.fifo_deq), 64'd0);
    chk("midrst_leaf_wpatch", 64'(bus_if.leaf_wpatch), 64'd0);
    chk("midrst_leaf_waddr", 64'(bus_if.leaf_waddr), 64'd0);
    chk("midrst_node_waddr", 64'(bus_if.node_waddr), 64'd0);
    repeat (2) tick();
    rst = 1'b0;
    repeat (2) tick();

    // Full load with a FIFO gap inside query 0 and a stray load during QUERIES
    gap_en = 1'b1;
    pulse_load();
    for (c = 0; c < 100 && !bus_if.node_wen; c++) tick();
    chk("restart_node_wen", 64'(bus_if.node_wen), 64'd1);
    chk("restart_node_waddr", 64'(bus_if.node_waddr), 64'd0);
    for (c = 0; c < 10000 && n_query < 100; c++) tick();
    chk("wait_queries", 64'(n_query >= 100), 64'd1);
    pulse_load();
    for (c = 0; c < 10000 && n_done < 1; c++) tick();
    chk("wait_done", 64'(n_done), 64'd1);
    repeat (5) tick();
    chk("count_node", 64'(n_node), 64'(NUM_NODES));
    chk("count_leaf", 64'(n_leaf), 64'(NUM_LEAVES * LEAF_SIZE));
    chk("count_query", 64'(n_query), 64'(NUM_QUERYS));
    chk("count_done", 64'(n_done), 64'd1);
    chk("words_consumed", 64'(ptr), 64'(TOTAL));
    chk("final_busy", 64'(busy), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
